dmem_lsu: RTL and testbench

- Load/store initiator between the core's MEM stage and the word-organised data memory port.
- Accepts one byte, halfword or word request using the codebase's 3-bit size/sign code (whb).
- Splits accesses that cross a word boundary into two word-aligned beats, then merges, shifts and sign/zero-extends read data.
- Single outstanding transaction; memory side uses a req/gnt handshake with an rvalid return.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/dmem_lsu.sv | 167 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Holds whb size/sign codes, the LSU FSM state encoding and size decode.
package lsu_pkg;

    localparam logic [2:0] WHB_B  = 3'b000;
    localparam logic [2:0] WHB_H  = 3'b001;
    localparam logic [2:0] WHB_W  = 3'b010;
    localparam logic [2:0] WHB_BU = 3'b011;
    localparam logic [2:0] WHB_HU = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_WAIT0,
        ST_ISSUE1,
        ST_WAIT1,
        ST_RESP
    } lsu_state_t;

    // Access size in bytes; illegal codes map to 1 so masks stay sane.
    function automatic logic [2:0] size_of(input logic [2:0] whb);
        logic [2:0] n;
        case (whb)
            WHB_H, WHB_HU: n = 3'd2;
            WHB_W:         n = 3'd4;
            default:       n = 3'd1;
        endcase
        return n;
    endfunction

    // Stores only have signed-width codes; loads add the unsigned variants.
    function automatic logic whb_legal(input logic we, input logic [2:0] whb);
        return we ? (whb <= WHB_W) : (whb <= WHB_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: beat enables, lane-positioned store data, load merge.
// Ports: off/whb/wdata describe the access, rbuf0/1 the two read beats;
//        be8/wdata64 cover both beats, rdata is the extended load result,
//        split flags an access that crosses into the next word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  whb,
    input  logic [31:0] wdata,
    input  logic [31:0] rbuf0,
    input  logic [31:0] rbuf1,
    output logic [7:0]  be8,
    output logic [63:0] wdata64,
    output logic [31:0] rdata,
    output logic        split
);

    logic [2:0]  n;
    logic [7:0]  mask;
    logic [63:0] rd64;

    assign n = size_of(whb);

    always_comb begin
        mask = 8'h01;
        case (n)
            3'd2:    mask = 8'h03;
            3'd4:    mask = 8'h0F;
            default: mask = 8'h01;
        endcase
    end

    // The 8-bit mask spans both beats: low nibble beat 0, high nibble beat 1.
    assign be8     = mask << off;
    assign split   = ({1'b0, off} + n) > 3'd4;
    assign wdata64 = {32'b0, wdata} << {off, 3'b000};
    assign rd64    = {rbuf1, rbuf0} >> {off, 3'b000};

    always_comb begin
        rdata = rd64[31:0];
        case (whb)
            WHB_B:   rdata = {{24{rd64[7]}}, rd64[7:0]};
            WHB_H:   rdata = {{16{rd64[15]}}, rd64[15:0]};
            WHB_BU:  rdata = {24'b0, rd64[7:0]};
            WHB_HU:  rdata = {16'b0, rd64[15:0]};
            default: rdata = rd64[31:0];
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between MEM stage and a word-wide data memory port.
// Ports: req_* core request (valid/ready), resp_* one-cycle completion pulse,
//        mem_* beat request with req/gnt handshake and rvalid return.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_whb,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    lsu_state_t state_q;
    lsu_state_t state_d;

    logic              we_q;
    logic [2:0]        whb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       buf0_q;
    logic [31:0]       buf1_q;

    logic              accept;
    logic [2:0]        req_n;
    logic              req_cross;
    logic              req_bad;

    logic [7:0]        be8;
    logic [63:0]       wd64;
    logic [31:0]       rd_ext;
    logic              split;

    logic [ADDR_W-3:0] widx;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign req_n     = size_of(req_whb);
    assign req_cross = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;
    assign req_bad   = !whb_legal(req_we, req_whb)
                     || (!ALLOW_MISALIGNED && req_cross);

    lsu_align u_align (
        .off     (addr_q[1:0]),
        .whb     (whb_q),
        .wdata   (wdata_q),
        .rbuf0   (buf0_q),
        .rbuf1   (buf1_q),
        .be8     (be8),
        .wdata64 (wd64),
        .rdata   (rd_ext),
        .split   (split)
    );

    // Second beat address wraps naturally in the word-index width.
    assign widx  = addr_q[ADDR_W-1:2];
    assign addr0 = {widx, 2'b00};
    assign addr1 = {widx + WORD_ONE, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            whb_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                whb_q   <= req_whb;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
            end
            if (state_q == ST_WAIT0 && mem_rvalid) begin
                buf0_q <= mem_rdata;
            end
            if (state_q == ST_WAIT1 && mem_rvalid) begin
                buf1_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_bad ? ST_RESP : ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr0;
                mem_be    = be8[3:0];
                mem_wdata = we_q ? wd64[31:0] : '0;
                if (mem_gnt) begin
                    state_d = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (mem_rvalid) begin
                    state_d = (split && ALLOW_MISALIGNED) ? ST_ISSUE1 : ST_RESP;
                end
            end
            ST_ISSUE1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr1;
                mem_be    = be8[7:4];
                mem_wdata = we_q ? wd64[63:32] : '0;
                if (mem_gnt) begin
                    state_d = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (mem_rvalid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? '0 : rd_ext;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-level memory reference model,
// randomized memory timing, directed corner cases and random traffic.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_whb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_valid2;
    logic        req_ready2;
    logic        req_we2;
    logic [2:0]  req_whb2;
    logic [31:0] req_addr2;
    logic [31:0] req_wdata2;
    logic        resp_valid2;
    logic [31:0] resp_rdata2;
    logic        resp_err2;
    logic        mem_req2;
    logic        mem_we2;
    logic [31:0] mem_addr2;
    logic [3:0]  mem_be2;
    logic [31:0] mem_wdata2;
    logic        mem_gnt2;
    logic        mem_rvalid2 = 1'b0;
    logic [31:0] mem_rdata2;

    always #5 clk = ~clk;

    dmem_lsu #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_whb(req_whb), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    dmem_lsu #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) u_dut_strict (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_whb(req_whb2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .resp_err(resp_err2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_gnt(mem_gnt2),
        .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2)
    );

    // Strict instance: always-grant memory holding a single fixed word.
    assign mem_gnt2   = mem_req2;
    assign mem_rdata2 = 32'hF3E2D1C0;
    always @(posedge clk) mem_rvalid2 <= (mem_req2 === 1'b1);

    int nreq2 = 0;
    always @(negedge clk) if (mem_req2 === 1'b1) nreq2++;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    resp_t exp_q[$];
    beat_t beat_q[$];

    logic [31:0] dmem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [31:0] wa;
        logic [31:0] w;
        wa = a & ~32'h3;
        if (!rmem.exists(wa)) rmem[wa] = init_word(wa);
        w = rmem[wa];
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic void ref_wr(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] wa;
        logic [31:0] w;
        wa = a & ~32'h3;
        if (!rmem.exists(wa)) rmem[wa] = init_word(wa);
        w = rmem[wa];
        w[8*a[1:0] +: 8] = b;
        rmem[wa] = w;
    endfunction

    // Reference: walk the accessed bytes one at a time; each byte lands in
    // whichever memory word holds it, which yields the expected beats.
    task automatic model(input logic we, input logic [2:0] whb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        bit          legal;
        resp_t       r;
        beat_t       b0;
        beat_t       b1;
        logic [31:0] v;
        logic [31:0] base;
        logic [31:0] a;
        logic [7:0]  byt;
        n = (whb == 3'd0 || whb == 3'd3) ? 1 :
            (whb == 3'd1 || whb == 3'd4) ? 2 : 4;
        legal = we ? (whb <= 3'd2) : (whb <= 3'd4);
        r.rdata = '0;
        r.err   = !legal;
        if (legal) begin
            base = addr & ~32'h3;
            b0 = '{base, 4'b0, we, 32'b0};
            b1 = '{base + 32'd4, 4'b0, we, 32'b0};
            v  = '0;
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                if (we) begin
                    byt = wdata[8*i +: 8];
                    ref_wr(a, byt);
                end else begin
                    byt = ref_rd(a);
                    v[8*i +: 8] = byt;
                end
                if ((a & ~32'h3) == base) begin
                    b0.be[a[1:0]] = 1'b1;
                    if (we) b0.wdata[8*a[1:0] +: 8] = byt;
                end else begin
                    b1.be[a[1:0]] = 1'b1;
                    if (we) b1.wdata[8*a[1:0] +: 8] = byt;
                end
            end
            if (!we) begin
                case (whb)
                    3'd0:    r.rdata = 32'($signed(v[7:0]));
                    3'd1:    r.rdata = 32'($signed(v[15:0]));
                    default: r.rdata = v;
                endcase
            end
            beat_q.push_back(b0);
            if (b1.be != 4'b0) beat_q.push_back(b1);
        end
        exp_q.push_back(r);
    endtask

    bit zero_wait = 1'b1;
    int gnt_force = -1;
    int rv_force  = -1;
    int ngnt      = 0;

    // Memory responder: checks each granted beat against the model's beat
    // list and checks that a stalled request holds steady.
    initial begin
        int          ph;
        int          cnt;
        beat_t       seen;
        beat_t       e;
        logic [31:0] rd;
        logic [31:0] w;
        logic [31:0] m;
        ph = 0;
        cnt = 0;
        rd = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (ph == 2) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd;
                    ph = 0;
                end else begin
                    cnt--;
                end
            end else if (mem_req === 1'b1) begin
                if (ph == 0) begin
                    seen = '{mem_addr, mem_be, mem_we, mem_wdata};
                    cnt = zero_wait ? 0 :
                          (gnt_force >= 0) ? gnt_force : int'($urandom_range(0, 2));
                    ph = 1;
                end else begin
                    chk("stall_hold",
                        {mem_addr, mem_be, mem_we, mem_wdata, req_ready},
                        {seen.addr, seen.be, seen.we, seen.wdata, 1'b0});
                end
                if (cnt == 0) begin
                    mem_gnt = 1'b1;
                    ngnt++;
                    if (beat_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat_unexpected: got addr=%0h be=%0h want none",
                                 mem_addr, mem_be);
                    end else begin
                        e = beat_q.pop_front();
                        chk("beat_addr", mem_addr, e.addr);
                        chk("beat_be", mem_be, e.be);
                        chk("beat_we", mem_we, e.we);
                        if (e.we) begin
                            m = '0;
                            for (int l = 0; l < 4; l++)
                                if (e.be[l]) m[8*l +: 8] = 8'hFF;
                            chk("beat_wdata", mem_wdata & m, e.wdata & m);
                        end
                    end
                    if (!dmem.exists(mem_addr)) dmem[mem_addr] = init_word(mem_addr);
                    w = dmem[mem_addr];
                    if (mem_we) begin
                        for (int l = 0; l < 4; l++)
                            if (mem_be[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
                        dmem[mem_addr] = w;
                    end
                    rd = w;
                    ph = 2;
                    cnt = zero_wait ? 0 :
                          (rv_force >= 0) ? rv_force : int'($urandom_range(0, 2));
                end else begin
                    cnt--;
                end
            end
        end
    end

    int    nresp    = 0;
    int    resp_cyc = 0;
    resp_t mon_r;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            nresp++;
            resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got rdata=%0h err=%0b want none",
                         resp_rdata, resp_err);
            end else begin
                mon_r = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_r.rdata);
                chk("resp_err", resp_err, mon_r.err);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] whb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat);
        int k;
        int acc;
        int n0;
        model(we, whb, addr, wdata);
        @(negedge clk);
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got=%0b want=1", req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_whb   = whb;
        req_addr  = addr;
        req_wdata = wdata;
        acc = cyc;
        n0  = nresp;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (nresp == n0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (nresp == n0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got=none want=resp addr=%0h", addr);
        end else if (exp_lat > 0) begin
            chk("latency", resp_cyc - acc, exp_lat);
        end
    endtask

    task automatic issue2(input logic we, input logic [2:0] whb,
                          input logic [31:0] addr, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_lat,
                          input int exp_beats);
        int k;
        int acc;
        int r0;
        bit got;
        @(negedge clk);
        chk("strict_ready", req_ready2, 1'b1);
        req_valid2 = 1'b1;
        req_we2    = we;
        req_whb2   = whb;
        req_addr2  = addr;
        req_wdata2 = 32'h0;
        acc = cyc;
        r0  = nreq2;
        got = 1'b0;
        k   = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            req_valid2 = 1'b0;
            k++;
            if (resp_valid2 === 1'b1) begin
                got = 1'b1;
                chk("strict_lat", cyc - acc, exp_lat);
                chk("strict_err", resp_err2, exp_err);
                chk("strict_rdata", resp_rdata2, exp_rd);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL strict_timeout: got=none want=resp");
        end
        chk("strict_beats", nreq2 - r0, exp_beats);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g0;
        int          n0;
        int          k;
        logic        we;
        logic [2:0]  whb;
        logic [31:0] addr;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_whb    = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_valid2 = 1'b0;
        req_we2    = 1'b0;
        req_whb2   = '0;
        req_addr2  = '0;
        req_wdata2 = '0;

        rmem[32'h100] = 32'hF3E2D1C0;
        rmem[32'h104] = 32'h87654321;
        dmem[32'h100] = 32'hF3E2D1C0;
        dmem[32'h104] = 32'h87654321;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_mem", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, 0);
        rst_n = 1'b1;

        zero_wait = 1'b1;
        issue(1'b0, 3'b000, 32'h103, 32'h0, 3);
        issue(1'b0, 3'b011, 32'h103, 32'h0, 3);
        issue(1'b0, 3'b001, 32'h103, 32'h0, 5);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5);
        issue(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 5);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 3);
        issue(1'b0, 3'b010, 32'h104, 32'h0, 3);
        issue(1'b0, 3'b101, 32'h100, 32'h0, 1);
        issue(1'b1, 3'b011, 32'h100, 32'h12345678, 1);
        issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 5);
        issue(1'b1, 3'b000, 32'h101, 32'h5555AA7E, 3);
        issue(1'b0, 3'b000, 32'h101, 32'h0, 3);

        zero_wait = 1'b0;
        gnt_force = 3;
        rv_force  = 0;
        issue(1'b1, 3'b010, 32'h105, 32'h13579BDF, 0);
        gnt_force = -1;

        // Abort a split load while it waits on the second beat.
        gnt_force = 0;
        rv_force  = 4;
        model(1'b0, 3'b001, 32'h107, 32'h0);
        @(negedge clk);
        g0 = ngnt;
        n0 = nresp;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_whb   = 3'b001;
        req_addr  = 32'h107;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (ngnt < g0 + 2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached_beat1", ngnt - g0, 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_resp_valid", resp_valid, 1'b0);
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        gnt_force = -1;
        rv_force  = -1;
        repeat (10) @(negedge clk);
        chk("abort_no_resp", nresp - n0, 0);
        chk("stray_ignored_ready", req_ready, 1'b1);

        issue(1'b0, 3'b010, 32'h104, 32'h0, 0);

        for (int t = 0; t < 150; t++) begin
            we  = 1'($urandom_range(0, 1));
            whb = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else
                addr = 32'h100 + 32'($urandom_range(0, 31));
            issue(we, whb, addr, $urandom, 0);
        end

        issue2(1'b0, 3'b010, 32'h101, 1'b1, 32'h0, 1, 0);
        issue2(1'b0, 3'b001, 32'h101, 1'b0, 32'hFFFFE2D1, 3, 1);
        issue2(1'b0, 3'b100, 32'h103, 1'b1, 32'h0, 1, 0);

        repeat (5) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("beat_q_drained", beat_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
